// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-writable simple dual-port RAM.
//   state_e    : sweep FSM states (idle / clearing)
//   DEPTH      : word count of the default 8-bit-address geometry
//   NUM_BYTES  : byte lanes of the default 32-bit word
//   byte_merge : replaces the masked byte lanes of a word; used both by the
//                write path and by the new-data read-during-write bypass.
//                Operates on a MAX_DATA_W container so any legal DATA_W fits.
package ram_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } state_e;

  localparam int unsigned DEPTH      = 256;
  localparam int unsigned NUM_BYTES  = 4;
  localparam int unsigned MAX_DATA_W = 256;
  localparam int unsigned MAX_BYTES  = MAX_DATA_W / 8;

  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BYTES-1:0]  mask
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < int'(MAX_BYTES); i++) begin
      if (mask[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_read_pipe.sv
// Read-data/valid delay line of READ_LATENCY stages (1 or 2).
//   clk_i   : clock
//   rst_i   : synchronous active-high flush; clears data and valid
//   valid_i : read accepted this cycle
//   data_i  : word read this cycle
//   valid_o : one-cycle pulse with each delivered result
//   data_o  : delivered word; holds its last value between results
module ram_read_pipe #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned DATA_W       = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic [READ_LATENCY-1:0] valid_q;
  logic [DATA_W-1:0]       data_q [READ_LATENCY];

  // Data stages only load alongside a valid so the output holds between reads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      if (valid_i) begin
        data_q[0] <= data_i;
      end
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign valid_o = valid_q[READ_LATENCY-1];
  assign data_o  = data_q[READ_LATENCY-1];

endmodule

// File: rtl/ram_sdp_bytewise.sv
// Simple dual-port RAM, one clock: byte-masked write port, pipelined read port
// and a hardware clear sweep that zeroes every word.
//   Clock    : single clock, rising edge
//   Reset    : synchronous active-high reset (restarts the sweep if enabled)
//   InSel    : write address          WrEn   : write strobe
//   ByteEn   : per-lane write mask    Input  : write data
//   OutSel   : read address           RdEn   : read strobe
//   Clear    : request a clear sweep (accepted only when idle)
//   Output   : read data, holds between results
//   OutValid : one-cycle pulse per read result
//   Busy     : high while the sweep runs (and during Reset when sweeping on reset)
module ram_sdp_bytewise
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned RDW_NEW        = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [ADDR_W-1:0]   InSel,
  input  logic                WrEn,
  input  logic [DATA_W/8-1:0] ByteEn,
  input  logic [DATA_W-1:0]   Input,
  input  logic [ADDR_W-1:0]   OutSel,
  input  logic                RdEn,
  input  logic                Clear,
  output logic [DATA_W-1:0]   Output,
  output logic                OutValid,
  output logic                Busy
);

  localparam int unsigned       Depth   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] AddrMax = '1;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [DATA_W-1:0] mem_q [Depth];

  logic              wr_act;
  logic              rd_act;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] rd_word;

  // User ports are locked out for the whole sweep.
  always_comb begin
    wr_act  = (state_q == StIdle) && WrEn && (ByteEn != '0);
    rd_act  = (state_q == StIdle) && RdEn;
    wr_word = DATA_W'(byte_merge(MAX_DATA_W'(mem_q[InSel]), MAX_DATA_W'(Input),
                                 MAX_BYTES'(ByteEn)));
    rd_word = mem_q[OutSel];
    // The merged write word is exactly the new-data view of the same address.
    if ((RDW_NEW != 0) && wr_act && (OutSel == InSel)) begin
      rd_word = wr_word;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= (CLEAR_ON_RESET != 0) ? StClear : StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (Clear) begin
            state_q <= StClear;
          end
        end
        StClear: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == AddrMax) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Single write port shared by the sweep and the user; contents are never reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      if (state_q == StClear) begin
        mem_q[cnt_q] <= '0;
      end else if (wr_act) begin
        mem_q[InSel] <= wr_word;
      end
    end
  end

  assign Busy = (state_q == StClear) || ((CLEAR_ON_RESET != 0) && Reset);

  ram_read_pipe #(
    .READ_LATENCY(READ_LATENCY),
    .DATA_W      (DATA_W)
  ) u_read_pipe (
    .clk_i  (Clock),
    .rst_i  (Reset),
    .valid_i(rd_act),
    .data_i (rd_word),
    .valid_o(OutValid),
    .data_o (Output)
  );

endmodule

// File: tb/tb_ram_sdp_bytewise.sv
// Bench for ram_sdp_bytewise: two instances share stimulus.
//   dut_a : READ_LATENCY=1, RDW_NEW=0     dut_b : READ_LATENCY=2, RDW_NEW=1
// A word-level memory model predicts Busy, OutValid and Output every cycle.
module tb_ram_sdp_bytewise;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_sel = '0;
  logic        wr_en = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] din = '0;
  logic [7:0]  out_sel = '0;
  logic        rd_en = 1'b0;
  logic        clr = 1'b0;

  logic [31:0] dout_a, dout_b;
  logic        ov_a, ov_b, busy_a, busy_b;

  always #5 clk = ~clk;

  ram_sdp_bytewise #(
    .DATA_W(32), .ADDR_W(8), .READ_LATENCY(1), .RDW_NEW(0), .CLEAR_ON_RESET(1)
  ) dut_a (
    .Clock(clk), .Reset(rst), .InSel(in_sel), .WrEn(wr_en), .ByteEn(be), .Input(din),
    .OutSel(out_sel), .RdEn(rd_en), .Clear(clr), .Output(dout_a), .OutValid(ov_a),
    .Busy(busy_a)
  );

  ram_sdp_bytewise #(
    .DATA_W(32), .ADDR_W(8), .READ_LATENCY(2), .RDW_NEW(1), .CLEAR_ON_RESET(1)
  ) dut_b (
    .Clock(clk), .Reset(rst), .InSel(in_sel), .WrEn(wr_en), .ByteEn(be), .Input(din),
    .OutSel(out_sel), .RdEn(rd_en), .Clear(clr), .Output(dout_b), .OutValid(ov_b),
    .Busy(busy_b)
  );

  int checks = 0;
  int failures = 0;
  int edge_n = 0;

  // Model state
  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  logic [31:0] mmem [256];
  int          sweep_left = 0;
  rd_t         pq_a[$];
  rd_t         pq_b[$];
  logic [31:0] hold_a = '0;
  logic [31:0] hold_b = '0;

  // Observed results
  logic [31:0] got_a[$];
  logic [31:0] got_b[$];
  int first_a, first_b, last_a, last_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] m4);
    logic [31:0] m;
    m = {{8{m4[3]}}, {8{m4[2]}}, {8{m4[1]}}, {8{m4[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  task automatic model_edge();
    logic [31:0] old_w, new_w;
    if (rst) begin
      sweep_left = 256;
      pq_a.delete();
      pq_b.delete();
      hold_a = '0;
      hold_b = '0;
    end else if (sweep_left > 0) begin
      mmem[256 - sweep_left] = '0;
      sweep_left--;
    end else begin
      old_w = mmem[out_sel];
      new_w = merge(mmem[in_sel], din, be);
      if (rd_en) begin
        pq_a.push_back('{edge_n, old_w});
        pq_b.push_back('{edge_n + 1, (wr_en && in_sel == out_sel) ? new_w : old_w});
      end
      if (wr_en) mmem[in_sel] = new_w;
      if (clr) sweep_left = 256;
    end
  endtask

  task automatic compare();
    logic exp_va, exp_vb;
    exp_va = (pq_a.size() > 0) && (pq_a[0].due == edge_n);
    if (exp_va) hold_a = pq_a.pop_front().data;
    exp_vb = (pq_b.size() > 0) && (pq_b[0].due == edge_n);
    if (exp_vb) hold_b = pq_b.pop_front().data;
    chk("busy_a", 32'(busy_a), 32'((sweep_left > 0) || rst));
    chk("busy_b", 32'(busy_b), 32'((sweep_left > 0) || rst));
    chk("valid_a", 32'(ov_a), 32'(exp_va));
    chk("valid_b", 32'(ov_b), 32'(exp_vb));
    chk("out_a", dout_a, hold_a);
    chk("out_b", dout_b, hold_b);
    if (ov_a === 1'b1) begin
      if (got_a.size() == 0) first_a = edge_n;
      last_a = edge_n;
      got_a.push_back(dout_a);
    end
    if (ov_b === 1'b1) begin
      if (got_b.size() == 0) first_b = edge_n;
      last_b = edge_n;
      got_b.push_back(dout_b);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    compare();
  endtask

  task automatic idle();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
  endtask

  task automatic drain(input int n);
    idle();
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic clr_got();
    got_a.delete();
    got_b.delete();
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
    wr_en = 1'b1; in_sel = a; din = d; be = m;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    rd_en = 1'b1; out_sel = a;
    cyc();
    rd_en = 1'b0;
  endtask

  // Counts cycles with Busy high, starting with the current one; bounded.
  task automatic wait_idle(output int cnt);
    #1;
    cnt = busy_a ? 1 : 0;
    for (int i = 0; i < 400; i++) begin
      cyc();
      if (busy_a !== 1'b1) break;
      cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int e0;

    // 1: reset two cycles, sweep length, cleared contents
    rst = 1'b1;
    cyc();
    cyc();
    idle();
    wait_idle(n);
    chk("reset_sweep_len", n, 256);
    clr_got();
    rd_en = 1'b1;
    out_sel = 8'd0;   cyc();
    out_sel = 8'd127; cyc();
    out_sel = 8'd255; cyc();
    drain(3);
    chk("cleared_cnt_a", got_a.size(), 3);
    chk("cleared_cnt_b", got_b.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("cleared_a", got_a[i], 32'h0000_0000);
      chk("cleared_b", got_b[i], 32'h0000_0000);
    end

    // 2: byte-lane write
    wr(8'h08, 32'h0000_0800, 4'b1111);
    wr(8'h08, 32'hAABB_CCDD, 4'b0010);
    wr(8'h08, 32'hFFFF_FFFF, 4'b0000);
    clr_got();
    rd(8'h08);
    drain(3);
    chk("lane_merge_a", got_a[0], 32'h0000_CC00);
    chk("lane_merge_b", got_b[0], 32'h0000_CC00);

    // 3: back-to-back reads, latency placement
    wr(8'h10, 32'h11, 4'b1111);
    wr(8'h11, 32'h22, 4'b1111);
    wr(8'h12, 32'h33, 4'b1111);
    clr_got();
    e0 = edge_n + 1;
    rd_en = 1'b1;
    out_sel = 8'h10; cyc();
    out_sel = 8'h11; cyc();
    out_sel = 8'h12; cyc();
    drain(3);
    chk("b2b_cnt_b", got_b.size(), 3);
    chk("b2b_b0", got_b[0], 32'h11);
    chk("b2b_b1", got_b[1], 32'h22);
    chk("b2b_b2", got_b[2], 32'h33);
    chk("lat2_first", first_b - e0, 1);
    chk("lat2_span", last_b - first_b, 2);
    chk("lat1_first", first_a - e0, 0);
    chk("b2b_a2", got_a[2], 32'h33);

    // 4: same-address read during write
    wr(8'h20, 32'hFFFF_FFFF, 4'b1111);
    clr_got();
    wr_en = 1'b1; in_sel = 8'h20; din = 32'h1234_5678; be = 4'b0001;
    rd_en = 1'b1; out_sel = 8'h20;
    cyc();
    // different-address read alongside a write
    in_sel = 8'h21; din = 32'hCAFE_F00D; be = 4'b1111; out_sel = 8'h20;
    cyc();
    drain(3);
    chk("rdw_old_a", got_a[0], 32'hFFFF_FFFF);
    chk("rdw_new_b", got_b[0], 32'hFFFF_FF78);
    chk("rdw_diff_a", got_a[1], 32'hFFFF_FF78);
    clr_got();
    rd(8'h21);
    drain(3);
    chk("diff_addr_wr", got_b[0], 32'hCAFE_F00D);

    // 5: clear with in-flight read, held Clear and ignored writes
    wr(8'h05, 32'h0000_DEAD, 4'b1111);
    clr_got();
    clr = 1'b1; rd_en = 1'b1; out_sel = 8'h05;
    cyc();
    rd_en = 1'b0;
    wr_en = 1'b1; in_sel = 8'h05; din = 32'h0000_1234; be = 4'b1111;
    cyc();
    cyc();
    rd_en = 1'b1;
    cyc();
    idle();
    wait_idle(n);
    drain(2);
    chk("inflight_cnt_a", got_a.size(), 1);
    chk("inflight_a", got_a[0], 32'h0000_DEAD);
    chk("inflight_b", got_b[0], 32'h0000_DEAD);
    clr_got();
    rd(8'h05);
    rd(8'h21);
    drain(3);
    chk("post_clear5_a", got_a[0], 32'h0);
    chk("post_clear21_b", got_b[1], 32'h0);

    // 6: reset in the middle of a sweep, reads ignored while busy
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    clr_got();
    rd_en = 1'b1; out_sel = 8'h00;
    for (int i = 0; i < 100; i++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    wait_idle(n);
    rd_en = 1'b0;
    chk("restart_sweep_len", n, 256);
    chk("busy_no_valid_a", got_a.size(), 0);
    chk("busy_no_valid_b", got_b.size(), 0);
    drain(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
